// File: rtl/sha256_block_core.sv
// Single-block SHA-256 compression from the standard IV, one round per clock.
// Digest is valid 65 cycles after acceptance and is held until the initiator soft-clears.
module sha256_block_core #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sha_reset_n,
  input  logic         sha_init,
  input  logic [511:0] sha_block,
  output logic         sha_ready,
  output logic [255:0] sha_digest,
  output logic         sha_digest_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ROUNDS, S_FINAL, S_DONE} state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // K[0] sits in the top word so round t reads slice (63 - t).
  localparam logic [2047:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t        state_q;
  logic [5:0]    cnt_q;
  logic [31:0]   a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
  logic [31:0]   w_q [16];
  logic          ready_q, valid_q;
  logic [255:0]  digest_q;

  logic [31:0]   k_t, s0, s1, ch, maj, t1, t2, a_d, e_d, w_d;
  logic [255:0]  digest_d;

  always_comb begin
    k_t = K_ROM[{~cnt_q, 5'd0} +: 32];
    s1  = rotr(e_q, 6) ^ rotr(e_q, 11) ^ rotr(e_q, 25);
    ch  = (e_q & f_q) ^ (~e_q & g_q);
    s0  = rotr(a_q, 2) ^ rotr(a_q, 13) ^ rotr(a_q, 22);
    maj = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
    t1  = h_q + s1 + ch + k_t + w_q[0];
    t2  = s0 + maj;
    a_d = t1 + t2;
    e_d = d_q + t1;
    // Window head is W[t]; the tail entry being produced is W[t+16].
    w_d = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
        + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    digest_d = {IV[255:224] + a_q, IV[223:192] + b_q, IV[191:160] + c_q, IV[159:128] + d_q,
                IV[127:96]  + e_q, IV[95:64]    + f_q, IV[63:32]    + g_q, IV[31:0]     + h_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= 256'd0;
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      digest_q <= 256'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sha_reset_n && sha_init) begin
            for (int i = 0; i < 16; i++) w_q[i] <= sha_block[511 - 32*i -: 32];
            {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= IV;
            cnt_q   <= 6'd0;
            ready_q <= 1'b0;
            state_q <= S_ROUNDS;
          end
        end
        S_ROUNDS: begin
          if (!sha_reset_n) begin
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            {a_q, b_q, c_q, d_q} <= {a_d, a_q, b_q, c_q};
            {e_q, f_q, g_q, h_q} <= {e_d, e_q, f_q, g_q};
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
            w_q[15] <= w_d;
            cnt_q   <= cnt_q + 6'd1;
            if (cnt_q == 6'(ROUNDS - 1)) state_q <= S_FINAL;
          end
        end
        S_FINAL: begin
          if (!sha_reset_n) begin
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            digest_q <= digest_d;
            valid_q  <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          // Further start requests are ignored until the initiator clears us.
          if (!sha_reset_n) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sha_ready        = ready_q;
  assign sha_digest_valid = valid_q;
  assign sha_digest       = digest_q;

endmodule

// File: tb/tb_sha256_block_core.sv
// Bench for sha256_block_core: known vectors plus random blocks against a full-schedule SHA-256 model.
module tb_sha256_block_core;

  logic         clk;
  logic         reset;
  logic         sha_reset_n;
  logic         sha_init;
  logic [511:0] sha_block;
  logic         sha_ready;
  logic [255:0] sha_digest;
  logic         sha_digest_valid;

  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] last_dig;

  sha256_block_core #(.ROUNDS(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .sha_reset_n      (sha_reset_n),
    .sha_init         (sha_init),
    .sha_block        (sha_block),
    .sha_ready        (sha_ready),
    .sha_digest       (sha_digest),
    .sha_digest_valid (sha_digest_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: expand all 64 schedule words first, then run the rounds.
  function automatic logic [255:0] sha_ref(input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = H0[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[0] = t1 + t2;
      v[4] = v[4] + t1;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = H0[i] + v[i];
    return res;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_hash(input string tag, input logic [511:0] blk);
    int n;
    n = 0;
    while (!(sha_ready && !sha_digest_valid) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {sha_ready, sha_digest_valid}, 2'b10);
    sha_reset_n = 1'b1;
    sha_block   = blk;
    sha_init    = 1'b1;
    tick();
    check({tag, "_busy"}, sha_ready, 1'b0);
  endtask

  task automatic wait_done(input string tag, input logic [255:0] exp, input bit float_bus);
    int n;
    if (float_bus) begin
      sha_block = 'z;
      sha_init  = 1'bz;
    end else begin
      sha_init = 1'b0;
    end
    n = 0;
    while (!sha_digest_valid && n < 100) begin
      if (!float_bus) sha_block = rand512();
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 65);
    check({tag, "_digest"}, sha_digest, exp);
    check({tag, "_ready"}, sha_ready, 1'b1);
    last_dig = exp;
  endtask

  task automatic release_core(input string tag);
    sha_reset_n = 1'b0;
    sha_init    = 1'b0;
    tick();
    check({tag, "_clr"}, {sha_ready, sha_digest_valid}, 2'b10);
    check({tag, "_dig_kept"}, sha_digest, last_dig);
    sha_reset_n = 1'b1;
  endtask

  task automatic run_hash(input string tag, input logic [511:0] blk, input logic [255:0] exp,
                          input bit float_bus);
    start_hash(tag, blk);
    wait_done(tag, exp, float_bus);
    release_core(tag);
  endtask

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  initial begin
    logic [511:0] blk;
    logic [255:0] exp;

    reset       = 1'b1;
    sha_reset_n = 1'($urandom_range(0, 1));
    sha_init    = 1'($urandom_range(0, 1));
    sha_block   = rand512();
    last_dig    = 256'd0;
    repeat (2) begin
      tick();
      sha_init  = 1'($urandom_range(0, 1));
      sha_block = rand512();
    end
    check("rst_ready", sha_ready, 1'b1);
    check("rst_valid", sha_digest_valid, 1'b0);
    check("rst_digest", sha_digest, 256'd0);
    reset       = 1'b0;
    sha_init    = 1'b0;
    sha_reset_n = 1'b1;
    tick();

    // Soft clear held low in IDLE blocks acceptance.
    sha_reset_n = 1'b0;
    sha_init    = 1'b1;
    sha_block   = rand512();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_nrst_noaccept", {sha_ready, sha_digest_valid}, 2'b10);
    end
    sha_init    = 1'b0;
    sha_reset_n = 1'b1;

    run_hash("abc", ABC_BLK, ABC_DIG, 1'b0);
    run_hash("empty_z", EMPTY_BLK, EMPTY_DIG, 1'b1);

    for (int i = 0; i < 2; i++) begin
      blk = rand512();
      run_hash("b2b", blk, sha_ref(blk), 1'b0);
    end

    // Abort just before round 30 executes.
    start_hash("abort", rand512());
    sha_init = 1'b0;
    repeat (30) tick();
    check("abort_midbusy", sha_ready, 1'b0);
    sha_reset_n = 1'b0;
    tick();
    check("abort_state", {sha_ready, sha_digest_valid}, 2'b10);
    check("abort_dig_kept", sha_digest, last_dig);
    repeat (70) tick();
    check("abort_stays_invalid", {sha_ready, sha_digest_valid}, 2'b10);
    sha_reset_n = 1'b1;
    run_hash("abc_after_abort", ABC_BLK, ABC_DIG, 1'b0);

    // DONE ignores further start requests until cleared.
    blk = rand512();
    exp = sha_ref(blk);
    start_hash("hold", blk);
    wait_done("hold", exp, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sha_init  = 1'(i % 2 == 0);
      sha_block = rand512();
      tick();
      check("hold_flags", {sha_ready, sha_digest_valid}, 2'b11);
      check("hold_digest", sha_digest, exp);
    end
    release_core("hold");
    tick();
    check("hold_no_new_hash", {sha_ready, sha_digest_valid}, 2'b10);

    for (int i = 0; i < 6; i++) begin
      blk = rand512();
      run_hash("rand", blk, sha_ref(blk), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
